// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//
// Arbitrates two writeback requesters (A = ALU, B = load unit) onto a single
// register-file write port.  After reset the block walks registers 1..31
// writing zero (CLEAR) and then arbitrates round-robin between A and B (RUN).
//
// Ports
//   i_clk        : clock, all state updates on the rising edge
//   i_reset      : synchronous active-low reset
//   i_a_valid    : requester A write request
//   i_a_rd       : requester A destination register (0 = no write)
//   i_a_data     : requester A write data
//   o_a_ready    : requester A accepted this cycle (combinational)
//   i_b_valid    : requester B write request
//   i_b_rd       : requester B destination register (0 = no write)
//   i_b_data     : requester B write data
//   o_b_ready    : requester B accepted this cycle (combinational)
//   o_rd         : register-file write address, 0 = no write (registered)
//   o_rd_data    : register-file write data (registered)
//   o_init_done  : post-reset register clear has finished (registered)
//   o_grant_b    : last issued write came from B (registered)
// ---------------------------------------------------------------------------
module regfile_write_arbiter (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_a_valid,
    input  logic [4:0]  i_a_rd,
    input  logic [31:0] i_a_data,
    output logic        o_a_ready,
    input  logic        i_b_valid,
    input  logic [4:0]  i_b_rd,
    input  logic [31:0] i_b_data,
    output logic        o_b_ready,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rd_data,
    output logic        o_init_done,
    output logic        o_grant_b
);

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_RUN   = 1'b1;

    logic       state;
    logic [4:0] clr_cnt;
    logic       rr_ptr;     // 0 = A has priority on contention

    logic a_write;
    logic b_write;
    logic active;
    logic grant_a;
    logic grant_b;

    // A request to r0 is a no-op: it is acknowledged but never competes
    // for the write slot.
    assign a_write = i_a_valid && (i_a_rd != 5'd0);
    assign b_write = i_b_valid && (i_b_rd != 5'd0);

    // Readies depend on i_reset directly so a request arriving on a reset
    // edge is never acknowledged.
    assign active  = (state == ST_RUN) && i_reset;

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (active) begin
            if (a_write && b_write) begin
                grant_a = !rr_ptr;
                grant_b = rr_ptr;
            end else begin
                grant_a = a_write;
                grant_b = b_write;
            end
        end
    end

    assign o_a_ready = active && i_a_valid && ((i_a_rd == 5'd0) || grant_a);
    assign o_b_ready = active && i_b_valid && ((i_b_rd == 5'd0) || grant_b);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= ST_CLEAR;
            clr_cnt     <= 5'd1;
            rr_ptr      <= 1'b0;
            o_rd        <= 5'd0;
            o_rd_data   <= 32'd0;
            o_init_done <= 1'b0;
            o_grant_b   <= 1'b0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    o_rd      <= clr_cnt;
                    o_rd_data <= 32'd0;
                    clr_cnt   <= clr_cnt + 5'd1;
                    if (clr_cnt == 5'd31) begin
                        state       <= ST_RUN;
                        o_init_done <= 1'b1;
                    end
                end
                default: begin
                    if (grant_a) begin
                        o_rd      <= i_a_rd;
                        o_rd_data <= i_a_data;
                        o_grant_b <= 1'b0;
                    end else if (grant_b) begin
                        o_rd      <= i_b_rd;
                        o_rd_data <= i_b_data;
                        o_grant_b <= 1'b1;
                    end else begin
                        o_rd      <= 5'd0;
                        o_rd_data <= 32'd0;
                    end
                    // The pointer only moves when both sides competed.
                    if (a_write && b_write) begin
                        rr_ptr <= !rr_ptr;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//
// Self-checking bench for regfile_write_arbiter.  The driver applies
// requests, checks the combinational readies against a request-level model
// and queues the register-file writes the model expects.  An independent
// monitor pops that queue whenever the DUT issues a write and checks idle
// cycles against the model's held grant / init_done values.
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

    typedef struct packed {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
    } req_t;

    typedef struct packed {
        logic        done;
        logic        gb;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0;
    logic [4:0]  a_rd = '0;
    logic [31:0] a_data = '0;
    logic        a_ready;
    logic        b_valid = 1'b0;
    logic [4:0]  b_rd = '0;
    logic [31:0] b_data = '0;
    logic        b_ready;
    logic [4:0]  rd;
    logic [31:0] rd_data;
    logic        init_done;
    logic        grant_b;

    regfile_write_arbiter dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_a_valid   (a_valid),
        .i_a_rd      (a_rd),
        .i_a_data    (a_data),
        .o_a_ready   (a_ready),
        .i_b_valid   (b_valid),
        .i_b_rd      (b_rd),
        .i_b_data    (b_data),
        .o_b_ready   (b_ready),
        .o_rd        (rd),
        .o_rd_data   (rd_data),
        .o_init_done (init_done),
        .o_grant_b   (grant_b)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    wr_t  exp_q[$];
    req_t ra = '0;
    req_t rb = '0;
    logic model_run = 1'b0;
    int   clear_idx = 1;
    logic ptr       = 1'b0;   // 1 = B wins the next contention
    logic last_gb   = 1'b0;
    logic exp_done  = 1'b0;
    logic mon_en    = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Hold reset low for n edges with random junk on the request ports.
    task automatic reset_dut(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n   = 1'b0;
            a_valid = 1'($urandom);
            a_rd    = 5'($urandom);
            b_valid = 1'($urandom);
            b_rd    = 5'($urandom);
            mon_en  = 1'b1;
            model_run = 1'b0;
            clear_idx = 1;
            ptr       = 1'b0;
            last_gb   = 1'b0;
            exp_done  = 1'b0;
            exp_q.delete();
            #1;
            check("reset_a_ready", 64'(a_ready), 64'd0);
            check("reset_b_ready", 64'(b_ready), 64'd0);
        end
        ra = '0;
        rb = '0;
    endtask

    // One clock cycle: drive ra/rb, predict and check readies, queue the
    // write expected on the coming edge.
    task automatic step(output logic ack_a, output logic ack_b);
        logic exp_a, exp_b, aw, bw;
        int   winner;   // 0 none, 1 A, 2 B
        @(negedge clk);
        rst_n   = 1'b1;
        a_valid = ra.v;
        a_rd    = ra.rd;
        a_data  = ra.d;
        b_valid = rb.v;
        b_rd    = rb.rd;
        b_data  = rb.d;
        #1;
        exp_a  = 1'b0;
        exp_b  = 1'b0;
        winner = 0;
        if (!model_run) begin
            exp_q.push_back('{done: (clear_idx == 31), gb: last_gb,
                              rd: 5'(clear_idx), data: 32'd0});
            if (clear_idx == 31) begin
                model_run = 1'b1;
                exp_done  = 1'b1;
            end
            clear_idx++;
        end else begin
            aw = ra.v && (ra.rd != 0);
            bw = rb.v && (rb.rd != 0);
            if (ra.v && ra.rd == 0) exp_a = 1'b1;
            if (rb.v && rb.rd == 0) exp_b = 1'b1;
            if (aw && bw) begin
                winner = ptr ? 2 : 1;
                ptr    = !ptr;
            end else if (aw) begin
                winner = 1;
            end else if (bw) begin
                winner = 2;
            end
            if (winner == 1) begin
                exp_a   = 1'b1;
                last_gb = 1'b0;
                exp_q.push_back('{done: 1'b1, gb: 1'b0, rd: ra.rd, data: ra.d});
            end else if (winner == 2) begin
                exp_b   = 1'b1;
                last_gb = 1'b1;
                exp_q.push_back('{done: 1'b1, gb: 1'b1, rd: rb.rd, data: rb.d});
            end
        end
        check("a_ready", 64'(a_ready), 64'(exp_a));
        check("b_ready", 64'(b_ready), 64'(exp_b));
        ack_a = exp_a;
        ack_b = exp_b;
    endtask

    // Step and retire whichever requests were accepted.
    task automatic step_retire();
        logic ka, kb;
        step(ka, kb);
        if (ka) ra.v = 1'b0;
        if (kb) rb.v = 1'b0;
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.v  = ($urandom_range(0, 9) < 6);
        r.rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
        r.d  = $urandom;
        return r;
    endfunction

    // Monitor: compare every post-edge output against the model.
    initial begin
        wr_t w;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (rd != 5'd0) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'(rd), 64'd0);
                    end else begin
                        w = exp_q.pop_front();
                        check("write", 64'({init_done, grant_b, rd, rd_data}),
                              64'(w));
                    end
                end else begin
                    check("idle", 64'({init_done, grant_b, rd_data}),
                          64'({exp_done, last_gb, 32'd0}));
                end
            end
        end
    end

    initial begin
        // Power-up reset and full clear with random traffic offered.
        reset_dut(2);
        for (int i = 0; i < 31; i++) begin
            if (!ra.v) ra = rand_req();
            if (!rb.v) rb = rand_req();
            step_retire();
        end

        // Randomized RUN traffic; unaccepted requests are held.
        for (int i = 0; i < 400; i++) begin
            if (!ra.v) ra = rand_req();
            if (!rb.v) rb = rand_req();
            step_retire();
        end
        ra = '0;
        rb = '0;
        step_retire();

        // Reset in the middle of RUN traffic, then a clear aborted at 12.
        ra = '{v: 1'b1, rd: 5'd9, d: 32'h1234};
        rb = '{v: 1'b1, rd: 5'd10, d: 32'h5678};
        reset_dut(1);
        for (int i = 0; i < 12; i++) step_retire();
        reset_dut(1);
        for (int i = 0; i < 31; i++) step_retire();

        // A alone, rd 5.
        ra = '{v: 1'b1, rd: 5'd5, d: 32'hDEADBEEF};
        step_retire();
        step_retire();

        // Continuous A (rd 1) and B (rd 2): A,B,A,B,A,B.
        for (int i = 0; i < 6; i++) begin
            ra = '{v: 1'b1, rd: 5'd1, d: 32'(i)};
            rb = '{v: 1'b1, rd: 5'd2, d: 32'(100 + i)};
            step_retire();
        end
        ra = '0;
        rb = '0;
        step_retire();

        // A to r0, B to r7: both acked, pointer untouched.
        ra = '{v: 1'b1, rd: 5'd0, d: 32'h99};
        rb = '{v: 1'b1, rd: 5'd7, d: 32'h55};
        step_retire();
        step_retire();

        // Same destination: A's data lands first, then B's.
        ra = '{v: 1'b1, rd: 5'd3, d: 32'h11};
        rb = '{v: 1'b1, rd: 5'd3, d: 32'h22};
        step_retire();
        step_retire();
        step_retire();
        step_retire();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
